// File: rtl/general_pack.sv
// Shared helpers and types for the Avalon-ST message path.
// msg_sm_t lives here so that monitors can decode the guard's state.
package general_pack;

    // Returns ceil(log2(n)), with a minimum of 1 bit.
    function automatic int log2up_func(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    typedef enum logic [1:0] {
        BETWEEN_MSG,
        IN_MSG,
        DISCARD
    } msg_sm_t;

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST beat bundle (valid/rdy/sop/eop/data/empty).
// A beat transfers on a posedge where valid & rdy are both 1. While valid=1 and rdy=0,
// the master holds valid and all beat fields stable. rdy may be asserted with valid low.
interface avalon_st_if
    import general_pack::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    localparam int EMPTY_W = log2up_func(DATA_WIDTH_IN_BYTES);

    logic                             valid;
    logic                             rdy;
    logic                             sop;
    logic                             eop;
    logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
    logic [EMPTY_W-1:0]               empty;

    modport master (output valid, sop, eop, data, empty, input rdy);
    modport slave  (input valid, sop, eop, data, empty, output rdy);
endinterface

// File: rtl/avalon_st_skid_buffer.sv
// Two-entry register slice for avalon_st_if. Both the output beat and the input rdy are
// registered, so there is no combinational path from out_msg.rdy to in_msg.rdy.
module avalon_st_skid_buffer
    import general_pack::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16
) (
    input logic        clk,
    input logic        rst,
    avalon_st_if.slave  in_msg,
    avalon_st_if.master out_msg
);
    localparam int EMPTY_W = log2up_func(DATA_WIDTH_IN_BYTES);
    localparam int BEAT_W  = 2 + EMPTY_W + 8 * DATA_WIDTH_IN_BYTES;

    logic [BEAT_W-1:0] in_beat;
    logic [BEAT_W-1:0] out_beat;
    logic [BEAT_W-1:0] skid_beat;
    logic              out_valid;
    logic              skid_valid;
    logic              in_rdy;
    logic              push;
    logic              out_free;

    assign in_beat  = {in_msg.sop, in_msg.eop, in_msg.empty, in_msg.data};
    assign push     = in_msg.valid & in_rdy;
    assign out_free = ~out_valid | out_msg.rdy;

    // in_rdy tracks !skid_valid one cycle ahead, so a push never meets an occupied skid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_rdy     <= 1'b0;
            out_beat   <= '0;
            skid_beat  <= '0;
        end else begin
            in_rdy <= ~skid_valid;
            if (out_free) begin
                in_rdy <= 1'b1;
                if (skid_valid) begin
                    out_beat   <= skid_beat;
                    out_valid  <= 1'b1;
                    skid_valid <= 1'b0;
                end else begin
                    out_valid <= push;
                    if (push) out_beat <= in_beat;
                end
            end else if (push) begin
                skid_beat  <= in_beat;
                skid_valid <= 1'b1;
                in_rdy     <= 1'b0;
            end
        end
    end

    assign in_msg.rdy    = in_rdy;
    assign out_msg.valid = out_valid;
    assign {out_msg.sop, out_msg.eop, out_msg.empty, out_msg.data} = out_beat;

endmodule

// File: rtl/avalon_msg_guard.sv
// Message-framing guard between an untrusted Avalon-ST source and trusted logic:
// drops stray beats/SOPs, truncates over-length messages, zeroes empty bytes on EOP.
module avalon_msg_guard
    import general_pack::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int MAX_MSG_LEN_WORDS   = 64,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    avalon_st_if.slave           untrusted_msg,
    avalon_st_if.master          enforced_msg,
    input  logic                 clear_cnt,
    output logic                 missing_sop_indi,
    output logic                 unexpected_sop_indi,
    output logic                 oversize_indi,
    output logic [CNT_WIDTH-1:0] missing_sop_cnt,
    output logic [CNT_WIDTH-1:0] unexpected_sop_cnt,
    output logic [CNT_WIDTH-1:0] oversize_cnt
);
    localparam int DATA_W     = 8 * DATA_WIDTH_IN_BYTES;
    localparam int EMPTY_W    = log2up_func(DATA_WIDTH_IN_BYTES);
    localparam int BEAT_CNT_W = log2up_func(MAX_MSG_LEN_WORDS + 1);
    localparam logic [BEAT_CNT_W-1:0] MAX_BEATS = BEAT_CNT_W'(MAX_MSG_LEN_WORDS);

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(DATA_WIDTH_IN_BYTES)) cleaned_msg ();

    msg_sm_t                 msg_state;
    msg_sm_t                 state_nxt;
    logic [BEAT_CNT_W-1:0]   beat_cnt;
    logic [BEAT_CNT_W-1:0]   cnt_nxt;
    logic                    accept;
    logic                    fwd;
    logic                    out_eop;
    logic [EMPTY_W-1:0]      out_empty;
    logic [DATA_W-1:0]       out_data;
    logic                    ev_missing;
    logic                    ev_unexp;
    logic                    ev_over;

    assign untrusted_msg.rdy = cleaned_msg.rdy;
    assign accept            = untrusted_msg.valid & cleaned_msg.rdy;

    always_comb begin
        state_nxt  = msg_state;
        cnt_nxt    = beat_cnt;
        fwd        = 1'b0;
        out_eop    = untrusted_msg.eop;
        ev_missing = 1'b0;
        ev_unexp   = 1'b0;
        ev_over    = 1'b0;
        if (accept) begin
            case (msg_state)
                BETWEEN_MSG: begin
                    if (untrusted_msg.sop) begin
                        fwd       = 1'b1;
                        cnt_nxt   = BEAT_CNT_W'(1);
                        state_nxt = untrusted_msg.eop ? BETWEEN_MSG : IN_MSG;
                    end else begin
                        ev_missing = 1'b1;
                    end
                end
                IN_MSG: begin
                    if (untrusted_msg.sop) begin
                        ev_unexp = 1'b1;
                    end else begin
                        fwd     = 1'b1;
                        cnt_nxt = beat_cnt + 1'b1;
                        if (untrusted_msg.eop) state_nxt = BETWEEN_MSG;
                    end
                end
                DISCARD: begin
                    if (untrusted_msg.eop) state_nxt = BETWEEN_MSG;
                end
                default: state_nxt = BETWEEN_MSG;
            endcase
        end
        // An EOP that lands exactly on the limit is a normal end, not a truncation.
        if (fwd && !untrusted_msg.eop && MAX_MSG_LEN_WORDS != 0 && cnt_nxt == MAX_BEATS) begin
            out_eop   = 1'b1;
            ev_over   = 1'b1;
            state_nxt = DISCARD;
        end
        out_empty = untrusted_msg.eop ? untrusted_msg.empty : '0;
        out_data  = untrusted_msg.data;
        for (int i = 0; i < DATA_WIDTH_IN_BYTES; i++) begin
            if (i < int'(out_empty)) out_data[8*i +: 8] = 8'h00;
        end
    end

    assign cleaned_msg.valid = fwd;
    assign cleaned_msg.sop   = (msg_state == BETWEEN_MSG);
    assign cleaned_msg.eop   = out_eop;
    assign cleaned_msg.empty = out_empty;
    assign cleaned_msg.data  = out_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_state           <= BETWEEN_MSG;
            beat_cnt            <= '0;
            missing_sop_indi    <= 1'b0;
            unexpected_sop_indi <= 1'b0;
            oversize_indi       <= 1'b0;
            missing_sop_cnt     <= '0;
            unexpected_sop_cnt  <= '0;
            oversize_cnt        <= '0;
        end else begin
            msg_state           <= state_nxt;
            beat_cnt            <= cnt_nxt;
            missing_sop_indi    <= ev_missing;
            unexpected_sop_indi <= ev_unexp;
            oversize_indi       <= ev_over;
            // Clear takes priority; counters stick once all ones.
            if (clear_cnt) begin
                missing_sop_cnt    <= '0;
                unexpected_sop_cnt <= '0;
                oversize_cnt       <= '0;
            end else begin
                if (ev_missing && missing_sop_cnt != '1) missing_sop_cnt <= missing_sop_cnt + 1'b1;
                if (ev_unexp && unexpected_sop_cnt != '1) unexpected_sop_cnt <= unexpected_sop_cnt + 1'b1;
                if (ev_over && oversize_cnt != '1) oversize_cnt <= oversize_cnt + 1'b1;
            end
        end
    end

    avalon_st_skid_buffer #(.DATA_WIDTH_IN_BYTES(DATA_WIDTH_IN_BYTES)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .in_msg  (cleaned_msg),
        .out_msg (enforced_msg)
    );

endmodule

// File: tb/tb_avalon_msg_guard.sv
// Bench for avalon_msg_guard: directed and random message traffic compared against
// a message-level reference model, with output beats matched through an expected queue.
module tb_avalon_msg_guard;
    localparam int DWB  = 8;
    localparam int MAXW = 4;
    localparam int CW   = 4;
    localparam int DW   = 8 * DWB;
    localparam int EW   = 3;
    localparam int BW   = 2 + EW + DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear_cnt = 1'b0;
    logic          miss_i, unexp_i, over_i;
    logic [CW-1:0] miss_c, unexp_c, over_c;

    avalon_st_if #(.DATA_WIDTH_IN_BYTES(DWB)) src_if ();
    avalon_st_if #(.DATA_WIDTH_IN_BYTES(DWB)) dst_if ();

    avalon_msg_guard #(
        .DATA_WIDTH_IN_BYTES(DWB),
        .MAX_MSG_LEN_WORDS  (MAXW),
        .CNT_WIDTH          (CW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .untrusted_msg      (src_if),
        .enforced_msg       (dst_if),
        .clear_cnt          (clear_cnt),
        .missing_sop_indi   (miss_i),
        .unexpected_sop_indi(unexp_i),
        .oversize_indi      (over_i),
        .missing_sop_cnt    (miss_c),
        .unexpected_sop_cnt (unexp_c),
        .oversize_cnt       (over_c)
    );

    // clock / reset
    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [BW-1:0] exp_q[$];
    bit            rand_rdy = 1'b0;

    // reference model: message-level view of the stream
    bit m_inside, m_swallow;
    int m_taken, m_miss, m_unexp, m_over;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_inside = 0; m_swallow = 0; m_taken = 0;
        m_miss = 0; m_unexp = 0; m_over = 0;
        exp_q.delete();
    endtask

    task automatic model_beat(input bit sop, input bit eop, input logic [EW-1:0] empty,
                              input logic [DW-1:0] data, input bit clr,
                              output bit e_miss, output bit e_unexp, output bit e_over);
        bit            first, last;
        int            n_empty;
        logic [DW-1:0] d;
        e_miss = 0; e_unexp = 0; e_over = 0;
        if (m_swallow) begin
            if (eop) m_swallow = 0;
        end else if (!m_inside && !sop) begin
            e_miss = 1;
        end else if (m_inside && sop) begin
            e_unexp = 1;
        end else begin
            first   = !m_inside;
            m_taken = first ? 1 : m_taken + 1;
            last    = eop;
            n_empty = eop ? int'(empty) : 0;
            if (!eop && m_taken == MAXW) begin
                last = 1; n_empty = 0; e_over = 1; m_swallow = 1;
            end
            m_inside = !last;
            d = data;
            for (int i = 0; i < DWB; i++) if (i < n_empty) d[8*i +: 8] = 8'h00;
            exp_q.push_back({first, last, EW'(n_empty), d});
        end
        if (clr) begin
            m_miss = 0; m_unexp = 0; m_over = 0;
        end else begin
            if (e_miss && m_miss < (1 << CW) - 1) m_miss++;
            if (e_unexp && m_unexp < (1 << CW) - 1) m_unexp++;
            if (e_over && m_over < (1 << CW) - 1) m_over++;
        end
    endtask

    // driver: present one beat, wait for acceptance, then check indications and counters
    task automatic send_beat(input bit sop, input bit eop, input logic [EW-1:0] empty,
                             input logic [DW-1:0] data, input bit clr);
        bit em, eu, eo;
        int waited;
        src_if.valid = 1'b1; src_if.sop = sop; src_if.eop = eop;
        src_if.empty = empty; src_if.data = data; clear_cnt = clr;
        waited = 0;
        @(negedge clk);
        while (src_if.rdy !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("src_rdy_wait", src_if.rdy, 1);
        @(posedge clk);
        #1;
        src_if.valid = 1'b0;
        clear_cnt = 1'b0;
        model_beat(sop, eop, empty, data, clr, em, eu, eo);
        check("missing_sop_indi", miss_i, em);
        check("unexpected_sop_indi", unexp_i, eu);
        check("oversize_indi", over_i, eo);
        check("missing_sop_cnt", miss_c, m_miss);
        check("unexpected_sop_cnt", unexp_c, m_unexp);
        check("oversize_cnt", over_c, m_over);
    endtask

    task automatic send_msg(input int len, input bit gaps);
        for (int b = 0; b < len; b++) begin
            send_beat(b == 0, b == len - 1, EW'($urandom_range(0, 7)), {$urandom, $urandom}, 0);
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 500) begin
            @(posedge clk);
            waited++;
        end
        #1;
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    // downstream rdy
    initial begin
        dst_if.rdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            dst_if.rdy = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // scoreboard / monitor: beats and hold-stability checked on the falling edge
    initial begin
        logic [BW-1:0] got, hold_val, want;
        bit            hold_pending;
        hold_pending = 0;
        hold_val = '0;
        forever begin
            @(negedge clk);
            got = {dst_if.sop, dst_if.eop, dst_if.empty, dst_if.data};
            if (hold_pending) begin
                check("hold_valid", dst_if.valid, 1);
                check("hold_beat", got, hold_val);
            end
            if (dst_if.valid === 1'b1 && dst_if.rdy === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", dst_if.valid, 0);
                end else begin
                    want = exp_q.pop_front();
                    check("out_beat", got, want);
                end
            end
            hold_pending = (dst_if.valid === 1'b1) && (dst_if.rdy !== 1'b1);
            hold_val = got;
        end
    end

    initial begin
        src_if.valid = 1'b0; src_if.sop = 1'b0; src_if.eop = 1'b0;
        src_if.empty = '0; src_if.data = '0;
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", dst_if.valid, 0);
        check("rst_src_rdy", src_if.rdy, 0);
        check("rst_cnts", {miss_c, unexp_c, over_c}, 0);
        check("rst_indis", {miss_i, unexp_i, over_i}, 0);
        #2 rst = 1'b0;
        #1 check("rdy_low_before_clk", src_if.rdy, 0);
        @(posedge clk);
        #1 check("rdy_high_after_clk", src_if.rdy, 1);

        // stray beats then a 4-beat message ending with empty=3
        for (int i = 0; i < 3; i++) send_beat(0, 0, 0, {$urandom, $urandom}, 0);
        send_beat(1, 0, 0, {$urandom, $urandom}, 0);
        send_beat(0, 0, 0, {$urandom, $urandom}, 0);
        send_beat(0, 0, 0, {$urandom, $urandom}, 0);
        send_beat(0, 1, 3, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        drain();
        check("t1_missing_cnt", miss_c, 3);

        // unexpected SOP inside a message
        send_beat(1, 0, 0, {$urandom, $urandom}, 0);
        send_beat(0, 0, 0, {$urandom, $urandom}, 0);
        send_beat(1, 0, 0, {$urandom, $urandom}, 0);
        send_beat(0, 0, 0, {$urandom, $urandom}, 0);
        send_beat(0, 1, 5, {$urandom, $urandom}, 0);
        drain();
        check("t2_unexpected_cnt", unexp_c, 1);

        // 7-beat message truncated at 4, then exactly-max and single-beat messages
        send_beat(1, 0, 0, {$urandom, $urandom}, 0);
        for (int i = 0; i < 5; i++) send_beat(i == 2, 0, 0, {$urandom, $urandom}, 0);
        send_beat(0, 1, 2, {$urandom, $urandom}, 0);
        send_msg(4, 0);
        send_msg(1, 0);
        drain();
        check("t3_oversize_cnt", over_c, 1);

        // random downstream backpressure with 200 legal messages
        rand_rdy = 1'b1;
        for (int m = 0; m < 200; m++) send_msg($urandom_range(1, MAXW), 1);
        drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;

        // reset during beat 2 of 5
        send_beat(1, 0, 0, {$urandom, $urandom}, 0);
        send_beat(0, 0, 0, {$urandom, $urandom}, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", dst_if.valid, 0);
        check("mid_rst_src_rdy", src_if.rdy, 0);
        check("mid_rst_cnts", {miss_c, unexp_c, over_c}, 0);
        model_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        send_beat(0, 0, 0, {$urandom, $urandom}, 0);
        send_beat(0, 0, 0, {$urandom, $urandom}, 0);
        send_beat(0, 1, 1, {$urandom, $urandom}, 0);
        check("t5_missing_cnt", miss_c, 3);

        // counter saturation, then clear colliding with an event
        for (int i = 0; i < (1 << CW) + 5; i++) send_beat(0, $urandom_range(0, 1), 0, {$urandom, $urandom}, 0);
        check("t6_missing_saturated", miss_c, (1 << CW) - 1);
        send_beat(0, 0, 0, {$urandom, $urandom}, 1);
        check("t6_clear_wins", miss_c, 0);
        send_msg(2, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
